// File: rtl/nv_ram_rwsp_80x514_fifo_ctrl_if.sv
// Push/pop handshake, RAM port and power-bus bundle for the 80x514 FIFO controller.
// slave = controller side, master = surrounding logic (producer, consumer and RAM macro).
interface nv_ram_rwsp_80x514_fifo_ctrl_if;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [513:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [513:0] rd_pd;
    logic [6:0]   fifo_count;
    logic         ram_we;
    logic [6:0]   ram_wa;
    logic [513:0] ram_di;
    logic         ram_re;
    logic [6:0]   ram_ra;
    logic         ram_ore;
    logic [513:0] ram_dout;
    logic [31:0]  pwrbus_ram_pd_in;
    logic [31:0]  pwrbus_ram_pd;

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd_in,
        output wr_prdy, rd_pvld, rd_pd, fifo_count,
        output ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore, pwrbus_ram_pd
    );

    modport master (
        output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd_in,
        input  wr_prdy, rd_pvld, rd_pd, fifo_count,
        input  ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore, pwrbus_ram_pd
    );
endinterface

// File: rtl/nv_ram_rwsp_80x514_fifo_ctrl.sv
// 80-entry FIFO controller around a 2-cycle registered RAM; push-to-pop latency 3 cycles when empty.
// Backpressure: wr_prdy drops at 80 entries (no same-cycle pop credit); rd_prdy stalls hold the output register.
module nv_ram_rwsp_80x514_fifo_ctrl (
    input  logic                                 nvdla_core_clk,
    input  logic                                 nvdla_core_rstn,
    nv_ram_rwsp_80x514_fifo_ctrl_if.slave        bus
);

    localparam logic [6:0] DEPTH    = 7'd80;
    localparam logic [6:0] LAST_IDX = 7'd79;

    function automatic logic [6:0] ptr_inc(input logic [6:0] p);
        return (p == LAST_IDX) ? 7'd0 : p + 7'd1;
    endfunction

    logic [6:0] wr_ptr_q,        wr_ptr_d;
    logic [6:0] fetch_ptr_q,     fetch_ptr_d;
    logic [6:0] unfetched_cnt_q, unfetched_cnt_d;
    logic [6:0] fifo_count_q,    fifo_count_d;
    logic       a_vld_q,         a_vld_d;
    logic       b_vld_q,         b_vld_d;

    logic wr_rdy;
    logic wr_acc;
    logic fetch;
    logic ore;
    logic pop;

    // Handshake decode; fetch may refill stage A in the same cycle it advances into B.
    always_comb begin
        wr_rdy = (fifo_count_q < DEPTH);
        wr_acc = bus.wr_pvld & wr_rdy;
        ore    = a_vld_q & (~b_vld_q | bus.rd_prdy);
        fetch  = (unfetched_cnt_q != 7'd0) & (~a_vld_q | ore);
        pop    = b_vld_q & bus.rd_prdy;
    end

    always_comb begin
        wr_ptr_d        = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        fetch_ptr_d     = fetch ? ptr_inc(fetch_ptr_q) : fetch_ptr_q;

        case ({wr_acc, fetch})
            2'b10:   unfetched_cnt_d = unfetched_cnt_q + 7'd1;
            2'b01:   unfetched_cnt_d = unfetched_cnt_q - 7'd1;
            default: unfetched_cnt_d = unfetched_cnt_q;
        endcase

        // Occupancy frees only on pop so the RAM never overwrites a word still in A or B.
        case ({wr_acc, pop})
            2'b10:   fifo_count_d = fifo_count_q + 7'd1;
            2'b01:   fifo_count_d = fifo_count_q - 7'd1;
            default: fifo_count_d = fifo_count_q;
        endcase

        a_vld_d = fetch | (a_vld_q & ~ore);
        b_vld_d = ore | (b_vld_q & ~bus.rd_prdy);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q        <= 7'd0;
            fetch_ptr_q     <= 7'd0;
            unfetched_cnt_q <= 7'd0;
            fifo_count_q    <= 7'd0;
            a_vld_q         <= 1'b0;
            b_vld_q         <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            fetch_ptr_q     <= fetch_ptr_d;
            unfetched_cnt_q <= unfetched_cnt_d;
            fifo_count_q    <= fifo_count_d;
            a_vld_q         <= a_vld_d;
            b_vld_q         <= b_vld_d;
        end
    end

    assign bus.wr_prdy       = wr_rdy;
    assign bus.ram_we        = wr_acc;
    assign bus.ram_wa        = wr_ptr_q;
    assign bus.ram_di        = bus.wr_pd;
    assign bus.ram_re        = fetch;
    assign bus.ram_ra        = fetch_ptr_q;
    assign bus.ram_ore       = ore;
    assign bus.rd_pvld       = b_vld_q;
    assign bus.rd_pd         = bus.ram_dout;
    assign bus.fifo_count    = fifo_count_q;
    assign bus.pwrbus_ram_pd = bus.pwrbus_ram_pd_in;

    // Every occupied entry is exactly one of: unfetched, in stage A, or in stage B.
    a_occupancy: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        fifo_count_q == unfetched_cnt_q + 7'(a_vld_q) + 7'(b_vld_q));

    a_count_max: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        fifo_count_q <= DEPTH);

    a_ptr_range: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (wr_ptr_q <= LAST_IDX) && (fetch_ptr_q <= LAST_IDX));

endmodule

// File: tb/tb_nv_ram_rwsp_80x514_fifo_ctrl.sv
// Random and directed bench: external registered RAM model plus a reference queue of accepted words.
module tb_nv_ram_rwsp_80x514_fifo_ctrl;

    localparam int DEPTH = 80;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nv_ram_rwsp_80x514_fifo_ctrl_if bus();

    nv_ram_rwsp_80x514_fifo_ctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus)
    );

    // RAM macro: address capture on ram_re, registered data on ram_ore, contents survive reset.
    logic [513:0] ram_mem [0:127];
    logic [6:0]   ram_ra_q;
    always @(posedge clk) begin
        if (bus.ram_we)  ram_mem[bus.ram_wa] <= bus.ram_di;
        if (bus.ram_re)  ram_ra_q <= bus.ram_ra;
        if (bus.ram_ore) bus.ram_dout <= ram_mem[ram_ra_q];
    end

    logic [513:0] mq [$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_pops = 0;
    logic         prev_stall = 1'b0;
    logic [513:0] prev_pd;
    logic         seen_vld;
    logic [513:0] seen_pd;
    logic         popped;
    logic [513:0] popped_pd;

    task automatic chk(input string tag, input logic [513:0] obs, input logic [513:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [513:0] rand_word();
        logic [543:0] t;
        for (int k = 0; k < 17; k++) t[k*32 +: 32] = $urandom;
        return t[513:0];
    endfunction

    // One clock: check at negedge, update the model at posedge, return 1ns after it.
    task automatic step();
        logic acc;
        logic pop;
        @(negedge clk);
        chk("fifo_count", 514'(bus.fifo_count), 514'(mq.size()));
        chk("wr_prdy", 514'(bus.wr_prdy), 514'(mq.size() < DEPTH));
        chk("pwrbus", 514'(bus.pwrbus_ram_pd), 514'(bus.pwrbus_ram_pd_in));
        if (prev_stall) begin
            chk("hold_vld", 514'(bus.rd_pvld), 514'(1));
            chk("hold_pd", bus.rd_pd, prev_pd);
        end
        acc = bus.wr_pvld && (mq.size() < DEPTH);
        pop = bus.rd_pvld && bus.rd_prdy;
        chk("ram_we", 514'(bus.ram_we), 514'(acc));
        if (bus.rd_pvld) begin
            if (mq.size() == 0) chk("rd_pvld_empty", 514'(bus.rd_pvld), 514'(0));
            else                chk("rd_pd", bus.rd_pd, mq[0]);
        end
        seen_vld   = bus.rd_pvld;
        seen_pd    = bus.rd_pd;
        popped     = pop;
        popped_pd  = bus.rd_pd;
        prev_stall = bus.rd_pvld && !bus.rd_prdy;
        prev_pd    = bus.rd_pd;
        @(posedge clk);
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(bus.wr_pd);
        if (pop) n_pops++;
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b1;
        n = 0;
        while (mq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        repeat (2) step();
        chk(tag, 514'(mq.size()), 514'(0));
    endtask

    initial begin
        int           lat;
        logic [513:0] lat_pd;
        int           bubbles;
        int           pops0;
        int           exp_idx;
        int           n;

        bus.wr_pvld          = 1'b0;
        bus.wr_pd            = '0;
        bus.rd_prdy          = 1'b0;
        bus.pwrbus_ram_pd_in = 32'h0;

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        bus.wr_pvld = 1'b1;
        #1;
        chk("rst_rd_pvld", 514'(bus.rd_pvld), 514'(0));
        chk("rst_ram_re", 514'(bus.ram_re), 514'(0));
        chk("rst_ram_ore", 514'(bus.ram_ore), 514'(0));
        chk("rst_wr_prdy", 514'(bus.wr_prdy), 514'(1));
        chk("rst_count", 514'(bus.fifo_count), 514'(0));
        chk("rst_ram_we", 514'(bus.ram_we), 514'(1));
        bus.wr_pvld = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single push into empty FIFO: rd_pvld three cycles after the push cycle.
        bus.pwrbus_ram_pd_in = 32'hDEAD_BEEF;
        bus.rd_prdy = 1'b1;
        bus.wr_pd   = 514'h155;
        bus.wr_pvld = 1'b1;
        step();
        bus.wr_pvld = 1'b0;
        lat = -1;
        lat_pd = '0;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            step();
            if (seen_vld) begin
                lat    = k;
                lat_pd = seen_pd;
            end
        end
        chk("latency", 514'(lat), 514'(3));
        chk("latency_pd", lat_pd, 514'h155);
        step();

        // Fill to 80 with consumer stalled, then one rejected push, then ordered drain.
        bus.rd_prdy = 1'b0;
        bus.wr_pvld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_pd = 514'(i);
            step();
        end
        bus.wr_pd = 514'h3FF;
        step();
        chk("full_count", 514'(bus.fifo_count), 514'(80));
        chk("full_wr_prdy", 514'(bus.wr_prdy), 514'(0));
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b1;
        exp_idx = 0;
        n = 0;
        while (mq.size() > 0 && n < 300) begin
            step();
            if (popped) begin
                chk("fill_order", popped_pd, 514'(exp_idx));
                exp_idx++;
            end
            n++;
        end
        chk("fill_pops", 514'(exp_idx), 514'(80));

        // Full with simultaneous push and pop: push rejected, count drops to 79.
        bus.rd_prdy = 1'b0;
        bus.wr_pvld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_pd = rand_word();
            step();
        end
        repeat (3) begin
            bus.wr_pvld = 1'b0;
            step();
        end
        bus.wr_pvld = 1'b1;
        bus.rd_prdy = 1'b1;
        bus.wr_pd   = rand_word();
        step();
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b0;
        @(negedge clk);
        chk("full_pushpop_count", 514'(bus.fifo_count), 514'(79));
        @(posedge clk);
        #1;
        drain("drain_full", 300);

        // Streaming with rd_prdy held high: one pop per cycle once the pipe fills.
        bus.rd_prdy = 1'b1;
        bus.wr_pvld = 1'b1;
        bubbles = 0;
        pops0 = n_pops;
        for (int i = 0; i < 500; i++) begin
            bus.wr_pd = 514'(1000 + i);
            step();
            if (i >= 3 && !seen_vld) bubbles++;
        end
        chk("stream_bubbles", 514'(bubbles), 514'(0));
        chk("stream_pops", 514'(n_pops - pops0), 514'(497));
        drain("drain_stream", 50);

        // Random push/stall traffic against the reference queue.
        for (int i = 0; i < 3000; i++) begin
            bus.wr_pvld = ($urandom_range(0, 9) < 7);
            bus.wr_pd   = rand_word();
            bus.rd_prdy = $urandom_range(0, 1) == 1;
            if (i % 97 == 0) bus.pwrbus_ram_pd_in = $urandom;
            step();
        end
        drain("drain_random", 300);

        // Reset mid-flight with both pipeline stages full.
        bus.rd_prdy = 1'b0;
        bus.wr_pvld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_pd = rand_word();
            step();
        end
        bus.wr_pvld = 1'b0;
        repeat (4) step();
        chk("pre_rst_vld", 514'(bus.rd_pvld), 514'(1));
        chk("pre_rst_count", 514'(bus.fifo_count), 514'(10));
        bus.rd_prdy = 1'b1;
        #1;
        chk("pre_rst_ore", 514'(bus.ram_ore), 514'(1));
        #1;
        bus.wr_pvld = 1'b1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_rd_pvld", 514'(bus.rd_pvld), 514'(0));
        chk("mid_rst_ram_re", 514'(bus.ram_re), 514'(0));
        chk("mid_rst_ram_ore", 514'(bus.ram_ore), 514'(0));
        chk("mid_rst_wr_prdy", 514'(bus.wr_prdy), 514'(1));
        chk("mid_rst_count", 514'(bus.fifo_count), 514'(0));
        chk("mid_rst_ram_we", 514'(bus.ram_we), 514'(1));
        bus.wr_pvld = 1'b0;
        mq.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.wr_pd   = 514'hA5;
        bus.wr_pvld = 1'b1;
        step();
        bus.wr_pvld = 1'b0;
        lat_pd = '0;
        n = 0;
        while (n < 10 && !seen_vld) begin
            step();
            n++;
        end
        chk("post_rst_first_vld", 514'(seen_vld), 514'(1));
        chk("post_rst_first_pd", seen_pd, 514'hA5);
        drain("drain_post_rst", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
